// File: rtl/sense_seq_pkg.sv
// Shared types and the channel-search helper for the LED/photo-sense sequencer.
package sense_seq_pkg;

    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic                found;
        logic [CH_IDX_W-1:0] idx;
    } ch_pick_t;

    // Lowest set channel whose index is >= lo; found=0 when none remains.
    function automatic ch_pick_t next_set_ch(input logic [MAX_CH-1:0] mask,
                                             input logic [3:0]        lo);
        ch_pick_t pick;
        pick = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(lo))) begin
                pick.found = 1'b1;
                pick.idx   = CH_IDX_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-stage flop synchroniser for asynchronous comparator inputs.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // NOTE: every stage of this small array is reset; it is a handful of flops,
    // not a RAM, and a known post-reset value keeps the first votes deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/sense_seq_ctrl.sv
// Per-sweep LED drive / settle / majority-vote sample / dead-time sequencer
// publishing an atomically updated result vector once per sweep.
module sense_seq_ctrl
    import sense_seq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int DEB         = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             continuous,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [CNT_W-1:0] settle_cyc,
    input  logic [CNT_W-1:0] hold_cyc,
    input  logic [N_CH-1:0]  comp_in,
    output logic [N_CH-1:0]  led_en,
    output logic             sample_stb,
    output logic             busy,
    output logic [N_CH-1:0]  result,
    output logic             result_valid
);

    localparam int                VOTE_W      = $clog2(DEB + 1);
    localparam logic [VOTE_W-1:0] SAMPLE_LAST = VOTE_W'(DEB - 1);
    localparam logic [VOTE_W-1:0] MAJORITY    = VOTE_W'(DEB / 2);

    function automatic logic [N_CH-1:0] onehot(input logic [CH_IDX_W-1:0] idx);
        return N_CH'(1) << idx;
    endfunction

    function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - CNT_W'(1);
    endfunction

    seq_state_t          state;
    logic [CH_IDX_W-1:0] ch_q;
    logic [N_CH-1:0]     mask_q;
    logic [CNT_W-1:0]    settle_q;
    logic [CNT_W-1:0]    hold_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [VOTE_W-1:0]   samp_cnt_q;
    logic [VOTE_W-1:0]   ones_q;
    logic [N_CH-1:0]     shadow_q;
    logic [N_CH-1:0]     comp_sync;

    sync_chain #(
        .WIDTH  (N_CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (comp_in),
        .q     (comp_sync)
    );

    ch_pick_t            first_pick;
    ch_pick_t            next_pick;
    logic [N_CH-1:0]     ch_sel;
    logic                sample_last;
    logic [VOTE_W-1:0]   ones_total;
    logic [N_CH-1:0]     shadow_next;
    logic                go;
    seq_state_t          ent_state;
    logic [CH_IDX_W-1:0] ent_ch;
    logic [CNT_W-1:0]    ent_settle;
    logic                ent_relatch;
    logic                sweep_done;

    // NOTE: every variable gets a default at the top of this block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        first_pick  = next_set_ch(MAX_CH'(ch_mask), 4'd0);
        next_pick   = next_set_ch(MAX_CH'(mask_q), 4'(ch_q) + 4'd1);
        ch_sel      = onehot(ch_q);
        sample_last = (state == SAMPLE) && (samp_cnt_q == SAMPLE_LAST);
        ones_total  = ones_q + VOTE_W'(|(comp_sync & ch_sel));
        shadow_next = shadow_q;
        if (sample_last) begin
            shadow_next = (shadow_q & ~ch_sel) | ((ones_total > MAJORITY) ? ch_sel : '0);
        end

        case (state)
            IDLE:    go = start && ena && first_pick.found;
            SAMPLE:  go = sample_last && (hold_q == '0);
            HOLD:    go = (cnt_q == '0);
            default: go = 1'b0;
        endcase

        // Where the sequencer lands when it enters a channel or finishes a sweep.
        ent_state   = IDLE;
        ent_ch      = ch_q;
        ent_settle  = settle_q;
        ent_relatch = 1'b0;
        sweep_done  = 1'b0;
        if (state == IDLE) begin
            ent_relatch = 1'b1;
            ent_ch      = first_pick.idx;
            ent_settle  = settle_cyc;
            ent_state   = (settle_cyc == '0) ? SAMPLE : SETTLE;
        end else if (next_pick.found) begin
            ent_ch    = next_pick.idx;
            ent_state = (settle_q == '0) ? SAMPLE : SETTLE;
        end else begin
            sweep_done = 1'b1;
            if (continuous && first_pick.found) begin
                ent_relatch = 1'b1;
                ent_ch      = first_pick.idx;
                ent_settle  = settle_cyc;
                ent_state   = (settle_cyc == '0) ? SAMPLE : SETTLE;
            end
        end
    end

    // NOTE: all state and outputs here use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch_q         <= '0;
            mask_q       <= '0;
            settle_q     <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            samp_cnt_q   <= '0;
            ones_q       <= '0;
            shadow_q     <= '0;
            led_en       <= '0;
            sample_stb   <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if ((state != IDLE) && !ena) begin
                state      <= IDLE;
                led_en     <= '0;
                sample_stb <= 1'b0;
                busy       <= 1'b0;
                shadow_q   <= '0;
            end else if (go) begin
                state      <= ent_state;
                ch_q       <= ent_ch;
                cnt_q      <= load_cnt(ent_settle);
                samp_cnt_q <= '0;
                ones_q     <= '0;
                led_en     <= (ent_state == IDLE) ? '0 : onehot(ent_ch);
                sample_stb <= (ent_state == SAMPLE);
                busy       <= (ent_state != IDLE);
                shadow_q   <= ent_relatch ? '0 : shadow_next;
                if (ent_relatch) begin
                    mask_q   <= ch_mask;
                    settle_q <= settle_cyc;
                    hold_q   <= hold_cyc;
                end
                if (sweep_done) begin
                    result       <= shadow_next & mask_q;
                    result_valid <= 1'b1;
                end
            end else begin
                case (state)
                    SETTLE: begin
                        if (cnt_q == '0) begin
                            state      <= SAMPLE;
                            sample_stb <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    SAMPLE: begin
                        ones_q   <= ones_total;
                        shadow_q <= shadow_next;
                        if (sample_last) begin
                            // A zero hold would have taken the go path above.
                            state      <= HOLD;
                            cnt_q      <= load_cnt(hold_q);
                            led_en     <= '0;
                            sample_stb <= 1'b0;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + VOTE_W'(1);
                        end
                    end
                    HOLD: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sense_seq_ctrl.sv
// Self-checking bench for sense_seq_ctrl: per-cycle LED/strobe/busy model plus
// a result scoreboard keyed on the cycle each result_valid is due.
module tb_sense_seq_ctrl;

    localparam int N_CH        = 4;
    localparam int CNT_W       = 8;
    localparam int DEB         = 3;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic [N_CH-1:0] res;
        int              at;
    } sb_entry_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             ena   = 1'b0;
    logic             start = 1'b0;
    logic             continuous = 1'b0;
    logic [N_CH-1:0]  ch_mask    = '0;
    logic [CNT_W-1:0] settle_cyc = '0;
    logic [CNT_W-1:0] hold_cyc   = '0;
    logic [N_CH-1:0]  comp_in    = '0;
    logic [N_CH-1:0]  led_en;
    logic             sample_stb;
    logic             busy;
    logic [N_CH-1:0]  result;
    logic             result_valid;

    sense_seq_ctrl #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DEB         (DEB),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .continuous   (continuous),
        .ch_mask      (ch_mask),
        .settle_cyc   (settle_cyc),
        .hold_cyc     (hold_cyc),
        .comp_in      (comp_in),
        .led_en       (led_en),
        .sample_stb   (sample_stb),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int        n_checks = 0;
    int        n_fail   = 0;
    sb_entry_t sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: result_valid must appear exactly on the cycles queued, nowhere else.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].at == cyc) begin
            check("result_valid", 32'(result_valid), 32'd1);
            check("result", 32'(result), 32'(sb[0].res));
            sb.delete(0);
        end else begin
            check("stray_valid", 32'(result_valid), 32'd0);
        end
    end

    function automatic int popcnt(input logic [N_CH-1:0] m);
        int c = 0;
        for (int i = 0; i < N_CH; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int nth_set(input logic [N_CH-1:0] m, input int n);
        int seen = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (m[i]) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return 0;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_led_en"}, 32'(led_en), 32'd0);
        check({tag, "_sample_stb"}, 32'(sample_stb), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    endtask

    // One single-shot sweep with static comparator inputs, traced cycle by cycle.
    task automatic run_sweep(input logic [N_CH-1:0] mask, input int settle, input int hold,
                             input logic [N_CH-1:0] comp, input bit disturb);
        int              n, per, e, idx, pos;
        logic [N_CH-1:0] exp_led;
        logic            exp_stb, exp_busy;
        sb_entry_t       ent;
        comp_in = comp;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        ch_mask    = mask;
        settle_cyc = CNT_W'(settle);
        hold_cyc   = CNT_W'(hold);
        start      = 1'b1;
        n   = popcnt(mask);
        per = settle + DEB + hold;
        e   = cyc + 1;
        ent.res = comp & mask;
        ent.at  = e + n * per;
        sb.push_back(ent);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n * per + 1; k++) begin
            exp_led  = '0;
            exp_stb  = 1'b0;
            exp_busy = 1'b0;
            if (k <= n * per) begin
                idx      = (k - 1) / per;
                pos      = (k - 1) % per;
                exp_led  = (pos < settle + DEB) ? (N_CH'(1) << nth_set(mask, idx)) : '0;
                exp_stb  = (pos >= settle) && (pos < settle + DEB);
                exp_busy = 1'b1;
            end
            check("led_en", 32'(led_en), 32'(exp_led));
            check("sample_stb", 32'(sample_stb), 32'(exp_stb));
            check("busy", 32'(busy), 32'(exp_busy));
            if (disturb && k == 4) begin
                ch_mask    = ~mask;
                settle_cyc = 8'd1;
                hold_cyc   = 8'd9;
                start      = 1'b1;
            end
            if (disturb && k == 5) start = 1'b0;
            @(negedge clk);
        end
    endtask

    // Channel 0 only: synchronised samples bits[0..DEB-1] land in the SAMPLE window,
    // surrounded by the opposite of the expected majority.
    task automatic run_vote(input logic [DEB-1:0] bits);
        int        e, j;
        logic      maj;
        sb_entry_t ent;
        maj        = popcnt(N_CH'(bits)) > DEB / 2;
        comp_in    = '0;
        comp_in[0] = ~maj;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        ch_mask    = N_CH'(1);
        settle_cyc = 8'd3;
        hold_cyc   = 8'd0;
        start      = 1'b1;
        e          = cyc + 1;
        ent.res    = N_CH'(maj);
        ent.at     = e + 3 + DEB;
        sb.push_back(ent);
        for (int k = 0; k < 3 + DEB + 3; k++) begin
            @(negedge clk);
            start      = 1'b0;
            j          = cyc - e - (3 - SYNC_STAGES);
            comp_in[0] = (j >= 0 && j < DEB) ? bits[j] : ~maj;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DEB-1:0] vote_tbl [4];
        sb_entry_t      ent;
        int             e;
        vote_tbl[0] = 3'b101;
        vote_tbl[1] = 3'b010;
        vote_tbl[2] = 3'b011;
        vote_tbl[3] = 3'b100;

        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        run_sweep(4'b1111, 3, 2, 4'b1010, 1'b0);
        run_sweep(4'b0101, 3, 2, 4'b1111, 1'b1);

        foreach (vote_tbl[i]) run_vote(vote_tbl[i]);

        // Abort during channel 2 SETTLE keeps the previous result.
        run_sweep(4'b0011, 3, 2, 4'b0011, 1'b0);
        comp_in = 4'b1111;
        @(negedge clk);
        ch_mask = 4'b1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        check("abort_pre_led", 32'(led_en), 32'h4);
        ena = 1'b0;
        @(negedge clk);
        check("abort_led", 32'(led_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'h3);
        repeat (4) @(negedge clk);
        check("abort_result_late", 32'(result), 32'h3);
        ena = 1'b1;

        // Continuous: back-to-back sweeps, then stop after the third.
        comp_in = 4'b1010;
        repeat (3) @(negedge clk);
        ch_mask    = 4'b1111;
        settle_cyc = 8'd3;
        hold_cyc   = 8'd2;
        continuous = 1'b1;
        start      = 1'b1;
        e          = cyc + 1;
        for (int s = 1; s <= 3; s++) begin
            ent.res = 4'b1010;
            ent.at  = e + 32 * s;
            sb.push_back(ent);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 97; k++) begin
            if (k == 33 || k == 65) begin
                check("cont_led", 32'(led_en), 32'h1);
                check("cont_busy", 32'(busy), 32'd1);
            end
            if (k == 65) continuous = 1'b0;
            if (k == 97) check("cont_end_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Start with an empty mask is ignored.
        ch_mask = '0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("mask0_busy", 32'(busy), 32'd0);
            check("mask0_led", 32'(led_en), 32'd0);
            @(negedge clk);
        end

        run_sweep(4'b1111, 0, 0, 4'b0110, 1'b0);

        // Asynchronous reset in the middle of SAMPLE.
        comp_in = 4'b1111;
        repeat (3) @(negedge clk);
        ch_mask    = 4'b1111;
        settle_cyc = 8'd3;
        hold_cyc   = 8'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_stb", 32'(sample_stb), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(4'b1001, 1, 1, 4'b1101, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
